// File: rtl/ps2_menu_key_decoder_if.sv
// PS/2 receive pins and menu-key outputs for ps2_menu_key_decoder.
// The slave modport is the decoder. The master modport is whatever drives the pins and reads the key.
// There is no valid/ready handshake on this bus.
// key is a level. key_stb and rx_err are single-cycle pulses on clk.
interface ps2_menu_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key;
  logic       key_stb;
  logic       rx_err;
  logic [1:0] dbg_rx_state;
  logic [1:0] dbg_dec_state;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  key,
    input  key_stb,
    input  rx_err,
    input  dbg_rx_state,
    input  dbg_dec_state
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output key,
    output key_stb,
    output rx_err,
    output dbg_rx_state,
    output dbg_dec_state
  );
endinterface

// File: rtl/ps2_menu_key_decoder.sv
// PS/2 set-2 receiver and scan-code decoder for the menu text drawer.
// It is receive only and never drives the PS/2 lines.
// key holds the current menu key. key_stb pulses on each accepted make code.
module ps2_menu_key_decoder #(
  parameter int TIMEOUT_CYCLES = 65_000
) (
  input  logic                   clk,
  input  logic                   rst,
  ps2_menu_key_decoder_if.slave  bus
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_RECV = 2'd1, RX_CHECK = 2'd2} rx_state_e;
  typedef enum logic [1:0] {DEC_BASE = 2'd0, DEC_BREAK = 2'd1, DEC_EXT = 2'd2, DEC_EXT_BREAK = 2'd3} dec_state_e;

  // Map a set-2 scan code to a menu key code. 0 means the code is not mapped.
  function automatic logic [3:0] map_code(input logic [7:0] code);
    case (code)
      8'h16:   map_code = 4'h1;
      8'h1E:   map_code = 4'h2;
      8'h26:   map_code = 4'h3;
      8'h25:   map_code = 4'h4;
      8'h76:   map_code = 4'hF;
      default: map_code = 4'h0;
    endcase
  endfunction

  logic clk_s1_q, clk_s2_q, clk_s3_q, dat_s1_q, dat_s2_q;
  logic fall;

  rx_state_e     rx_state_q, rx_state_d;
  logic [10:0]   shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] to_q, to_d;
  logic          byte_rdy, frame_err, timeout;
  logic [7:0]    rx_byte;
  logic          frame_ok;

  dec_state_e    dec_state_q, dec_state_d;
  logic [3:0]    key_q, key_d;
  logic          key_stb_q, key_stb_d;
  logic          rx_err_q, rx_err_d;
  logic [3:0]    mapped;

  // Synchronize both pins; the synchronizers reset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= bus.ps2_clk;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= bus.ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign fall = clk_s3_q & ~clk_s2_q;

  // After 11 shifts, shift_q holds stop, parity, d7..d0 and start from MSB down to LSB.
  assign rx_byte  = shift_q[8:1];
  assign frame_ok = ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      to_q       <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      to_q       <= to_d;
    end
  end

  // Receiver next state: shift in one bit per fall, then check the frame.
  // An idle gap mid-frame aborts the frame.
  // A fall takes priority over a timeout in the same cycle.
  always_comb begin
    rx_state_d = rx_state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    to_d       = to_q;
    byte_rdy   = 1'b0;
    frame_err  = 1'b0;
    timeout    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        to_d = '0;
        if (fall) begin
          shift_d    = {dat_s2_q, shift_q[10:1]};
          bit_cnt_d  = 4'd1;
          rx_state_d = RX_RECV;
        end
      end
      RX_RECV: begin
        if (fall) begin
          shift_d   = {dat_s2_q, shift_q[10:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          to_d      = '0;
          if (bit_cnt_q == 4'd10) rx_state_d = RX_CHECK;
        end else if (to_q == TO_LAST) begin
          timeout    = 1'b1;
          to_d       = '0;
          bit_cnt_d  = '0;
          rx_state_d = RX_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      RX_CHECK: begin
        bit_cnt_d  = '0;
        to_d       = '0;
        rx_state_d = RX_IDLE;
        if (frame_ok) byte_rdy  = 1'b1;
        else          frame_err = 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign mapped = map_code(rx_byte);

  // Decoder state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_state_q <= DEC_BASE;
      key_q       <= 4'h0;
      key_stb_q   <= 1'b0;
      rx_err_q    <= 1'b0;
    end else begin
      dec_state_q <= dec_state_d;
      key_q       <= key_d;
      key_stb_q   <= key_stb_d;
      rx_err_q    <= rx_err_d;
    end
  end

  // Decoder next state: follow the make, break and extended prefixes.
  // The decoder only advances when a byte has been accepted.
  always_comb begin
    dec_state_d = dec_state_q;
    key_d       = key_q;
    key_stb_d   = 1'b0;
    rx_err_d    = frame_err | timeout;
    if (byte_rdy) begin
      case (dec_state_q)
        DEC_BASE: begin
          if (rx_byte == 8'hF0)      dec_state_d = DEC_BREAK;
          else if (rx_byte == 8'hE0) dec_state_d = DEC_EXT;
          else if (mapped != 4'h0) begin
            key_d     = mapped;
            key_stb_d = 1'b1;
          end
        end
        DEC_BREAK: begin
          if (mapped != 4'h0 && mapped == key_q) key_d = 4'h0;
          dec_state_d = DEC_BASE;
        end
        DEC_EXT: begin
          if (rx_byte == 8'hF0) dec_state_d = DEC_EXT_BREAK;
          else                  dec_state_d = DEC_BASE;
        end
        DEC_EXT_BREAK: dec_state_d = DEC_BASE;
        default:       dec_state_d = DEC_BASE;
      endcase
    end
  end

  assign bus.key           = key_q;
  assign bus.key_stb       = key_stb_q;
  assign bus.rx_err        = rx_err_q;
  assign bus.dbg_rx_state  = rx_state_q;
  assign bus.dbg_dec_state = dec_state_q;

endmodule

// File: tb/tb_ps2_menu_key_decoder.sv
// Bench for ps2_menu_key_decoder.
// Directed PS/2 frames push the expected events into exp_q.
// A negedge monitor pops and compares every strobe, error or key change.
// Event encoding is {kind[1:0], key[3:0]}, where kind 1 is key_stb, 2 is rx_err and 3 is a key change without a strobe.
module tb_ps2_menu_key_decoder;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 8;
  localparam int GAP     = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   last_fall_cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  logic [3:0] prev_key = 4'h0;
  logic [5:0] got_ev, exp_ev;
  logic [5:0] exp_q[$];

  ps2_menu_key_decoder_if bus();

  ps2_menu_key_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.key_stb || bus.rx_err || (bus.key !== prev_key)) begin
        got_ev = bus.key_stb ? {2'd1, bus.key} : (bus.rx_err ? {2'd2, bus.key} : {2'd3, bus.key});
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event got=%h required=none @%0t", got_ev, $time);
        end else begin
          exp_ev = exp_q.pop_front();
          if (got_ev !== exp_ev) begin
            n_err++;
            $display("FAIL event got=%h required=%h @%0t", got_ev, exp_ev, $time);
          end
        end
        if (bus.key_stb) begin
          // Count 2 cycles of synchronizer, 1 for the fall and CHECK, and 1 to register the strobe.
          n_cmp++;
          if (cyc - last_fall_cyc != 4) begin
            n_err++;
            $display("FAIL stb_latency got=%0d required=4", cyc - last_fall_cyc);
          end
        end
      end
      prev_key = bus.key;
    end
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    @(negedge clk);
    bus.ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic [2:0] flt);
    // flt[0] flips parity, flt[1] sets the start bit, flt[2] clears the stop bit.
    mk_frame = {~flt[2], (~^b) ^ flt[0], b, flt[1]};
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic [2:0] flt);
    send_bits(mk_frame(b, flt), 11);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [3:0] k);
    exp_q.push_back({kind, k});
  endtask

  // Directed stimulus
  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_key", bus.key, 4'h0);
    check("reset_stb", {3'b0, bus.key_stb}, 4'h0);
    check("reset_err", {3'b0, bus.rx_err}, 4'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    prev_key = bus.key;
    mon_en = 1'b1;

    // Make 1E, then break 1E.
    expect_ev(2'd1, 4'h2); send_frame(8'h1E, 3'b000);
    expect_ev(2'd3, 4'h0); send_frame(8'hF0, 3'b000); send_frame(8'h1E, 3'b000);
    // Break of another key leaves key held.
    expect_ev(2'd1, 4'h2); send_frame(8'h1E, 3'b000);
    send_frame(8'hF0, 3'b000); send_frame(8'h26, 3'b000);

    // Frame errors: bad parity, bad start, bad stop.
    expect_ev(2'd2, 4'h2); send_frame(8'h76, 3'b001);
    expect_ev(2'd2, 4'h2); send_frame(8'h76, 3'b010);
    expect_ev(2'd2, 4'h2); send_frame(8'h76, 3'b100);

    // Timeout after six bits, then a valid 25.
    expect_ev(2'd2, 4'h2);
    send_bits(mk_frame(8'h76, 3'b000), 6);
    repeat (TIMEOUT + 40) @(negedge clk);
    expect_ev(2'd1, 4'h4); send_frame(8'h25, 3'b000);
    expect_ev(2'd3, 4'h0); send_frame(8'hF0, 3'b000); send_frame(8'h25, 3'b000);

    // Extended make and break never map.
    send_frame(8'hE0, 3'b000); send_frame(8'h75, 3'b000);
    send_frame(8'hE0, 3'b000); send_frame(8'hF0, 3'b000); send_frame(8'h75, 3'b000);
    expect_ev(2'd1, 4'h1); send_frame(8'h16, 3'b000);

    // Last key wins, plus typematic repeats.
    for (int i = 0; i < 3; i++) begin
      expect_ev(2'd1, 4'h3); send_frame(8'h26, 3'b000);
    end

    // Reset mid-frame, then a fresh ESC.
    send_bits(mk_frame(8'h76, 3'b000), 4);
    expect_ev(2'd3, 4'h0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    expect_ev(2'd1, 4'hF); send_frame(8'h76, 3'b000);

    repeat (50) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_events got=%0d pending required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
